// File: rtl/fetch_decode_pipe.sv
// Fetch/decode front end: PC register, instruction memory, IF/ID pipeline
// register, register file with PC alias and write-through bypass, and the
// immediate extender that produces the decode-stage operands.
module fetch_decode_pipe #(
   parameter int DATA_W  = 32,
   parameter int IMEM_AW = 6,
   parameter int NREGS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pc_src,
   input  logic [DATA_W-1:0]   result,
   input  logic [1:0]          reg_src,
   input  logic                reg_write,
   input  logic [3:0]          wb_addr,
   input  logic [1:0]          imm_src,
   input  logic                alu_src,
   input  logic                stall,
   input  logic                flush,
   input  logic                imem_we,
   input  logic [IMEM_AW-1:0]  imem_waddr,
   input  logic [31:0]         imem_wdata,
   output logic [DATA_W-1:0]   pc_f,
   output logic [31:0]         instr_d,
   output logic [DATA_W-1:0]   pc_d,
   output logic                valid_d,
   output logic [DATA_W-1:0]   src_a,
   output logic [DATA_W-1:0]   src_b,
   output logic [DATA_W-1:0]   write_data
);

   // The highest register index is not storage: reading it yields pc_d+8.
   localparam logic [3:0] PC_IDX = 4'(NREGS - 1);
   localparam int         IMEM_DEPTH = 1 << IMEM_AW;

   logic [31:0]       imem [0:IMEM_DEPTH-1];
   logic [31:0]       fetch_instr;
   logic [DATA_W-1:0] pc_next;
   logic [DATA_W-1:0] regs [0:NREGS-2];
   logic [DATA_W-1:0] pc_alias;
   logic [3:0]        ra1;
   logic [3:0]        ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] ext_imm;
   logic [31:0]       imm8_word;
   logic [4:0]        rot_amt;
   logic [31:0]       rot_word;
   logic [25:0]       branch_off;

   // Word-addressed fetch; upper PC bits are dropped so addresses alias.
   assign fetch_instr = imem[pc_f[IMEM_AW+1:2]];

   // Program loading is independent of reset so memory survives a reset and
   // can be filled while the pipeline is held in reset.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   // Next fetch address: a taken branch beats a stall, otherwise step by one word.
   always_comb begin
      pc_next = pc_f + DATA_W'(4);
      if (pc_src) begin
         pc_next = result;
      end else if (stall) begin
         pc_next = pc_f;
      end
   end

   // Fetch PC register; reset outranks every other control.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_f <= '0;
      end else begin
         pc_f <= pc_next;
      end
   end

   // IF/ID register: a branch or flush squashes the fetched word into a bubble
   // even when a stall is requested, so the wrong-path instruction never lingers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_d <= '0;
         pc_d    <= '0;
         valid_d <= 1'b0;
      end else if (flush || pc_src) begin
         instr_d <= '0;
         pc_d    <= '0;
         valid_d <= 1'b0;
      end else if (!stall) begin
         instr_d <= fetch_instr;
         pc_d    <= pc_f;
         valid_d <= 1'b1;
      end
   end

   // Register file storage; the PC alias and out-of-range indices are not writable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS - 1; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_write && (wb_addr < PC_IDX)) begin
         regs[wb_addr] <= result;
      end
   end

   // Read-address selection: port 1 may be forced to the PC alias, port 2 may
   // take the destination field instead of the usual second source field.
   always_comb begin
      ra1 = reg_src[0] ? PC_IDX : instr_d[19:16];
      ra2 = reg_src[1] ? instr_d[15:12] : instr_d[3:0];
   end

   // Value a read of the PC alias returns: decode PC plus two words of prefetch.
   assign pc_alias = pc_d + DATA_W'(8);

   // Read port 1 with write-through so a same-cycle writeback is seen at once.
   always_comb begin
      rd1 = '0;
      if (ra1 == PC_IDX) begin
         rd1 = pc_alias;
      end else if (reg_write && (wb_addr == ra1)) begin
         rd1 = result;
      end else if (ra1 < PC_IDX) begin
         rd1 = regs[ra1];
      end
   end

   // Read port 2, same priority as port 1.
   always_comb begin
      rd2 = '0;
      if (ra2 == PC_IDX) begin
         rd2 = pc_alias;
      end else if (reg_write && (wb_addr == ra2)) begin
         rd2 = result;
      end else if (ra2 < PC_IDX) begin
         rd2 = regs[ra2];
      end
   end

   // Pieces of the immediate formats: rotated 8-bit constant and word branch offset.
   always_comb begin
      imm8_word  = {24'b0, instr_d[7:0]};
      rot_amt    = {instr_d[11:8], 1'b0};
      rot_word   = (imm8_word >> rot_amt) | (imm8_word << (6'd32 - {1'b0, rot_amt}));
      branch_off = {instr_d[23:0], 2'b00};
   end

   // Immediate extender selected by imm_src.
   always_comb begin
      ext_imm = '0;
      case (imm_src)
         2'b00:   ext_imm = DATA_W'(instr_d[7:0]);
         2'b01:   ext_imm = DATA_W'(instr_d[11:0]);
         2'b10:   ext_imm = {{(DATA_W-26){branch_off[25]}}, branch_off};
         default: ext_imm = DATA_W'(rot_word);
      endcase
   end

   // Operand outputs handed to the execute stage.
   always_comb begin
      src_a      = rd1;
      write_data = rd2;
      src_b      = alu_src ? ext_imm : rd2;
   end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed self-checking bench for fetch_decode_pipe: one task per scenario,
// each with hand-computed expectations taken from a bench-side copy of the
// program image.
module tb_fetch_decode_pipe;

   logic        clk;
   logic        reset;
   logic        pc_src;
   logic [31:0] result;
   logic [1:0]  reg_src;
   logic        reg_write;
   logic [3:0]  wb_addr;
   logic [1:0]  imm_src;
   logic        alu_src;
   logic        stall;
   logic        flush;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        valid_d;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] write_data;

   logic [31:0] exp_mem [0:63];
   int vectors;
   int miscompares;

   fetch_decode_pipe #(.DATA_W(32), .IMEM_AW(6), .NREGS(16)) dut (
      .clk(clk), .reset(reset), .pc_src(pc_src), .result(result),
      .reg_src(reg_src), .reg_write(reg_write), .wb_addr(wb_addr),
      .imm_src(imm_src), .alu_src(alu_src), .stall(stall), .flush(flush),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
      .src_a(src_a), .src_b(src_b), .write_data(write_data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Program image with a few hand-picked words at fixed addresses.
   task automatic build_image();
      for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
      exp_mem[0]  = 32'hE3A0_1006;
      exp_mem[1]  = 32'hE281_2001;
      exp_mem[2]  = 32'hE081_3002;
      exp_mem[20] = 32'hE083_1002;
      exp_mem[21] = 32'h00FF_FFFE;
      exp_mem[22] = 32'h0000_04FF;
   endtask

   // Hold reset and load instruction memory through the write port.
   task automatic load_program();
      reset = 1'b0; pc_src = 1'b0; result = '0; reg_src = '0; reg_write = 1'b0;
      wb_addr = '0; imm_src = '0; alu_src = 1'b0; stall = 1'b0; flush = 1'b0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      step();
      for (int i = 0; i < 64; i++) begin
         imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = exp_mem[i];
         step();
      end
      imem_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; reg_src = 2'b00;
      step(); step();
      vectors++; if (pc_f !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc_f got %h want %h", pc_f, 32'h0); end
      vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid_d); end
      vectors++; if (instr_d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr got %h want 0", instr_d); end
      vectors++; if (pc_d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc_d got %h want 0", pc_d); end
      vectors++; if (src_a !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_src_a got %h want 0", src_a); end
   endtask

   task automatic test_seq_fetch();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++; if (instr_d !== exp_mem[k]) begin miscompares++; $display("[TB] FAIL seq_instr[%0d] got %h want %h", k, instr_d, exp_mem[k]); end
         vectors++; if (pc_d !== 32'(4*k)) begin miscompares++; $display("[TB] FAIL seq_pc_d[%0d] got %h want %h", k, pc_d, 32'(4*k)); end
         vectors++; if (valid_d !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_valid[%0d] got %b want 1", k, valid_d); end
         vectors++; if (pc_f !== 32'(4*k+4)) begin miscompares++; $display("[TB] FAIL seq_pc_f[%0d] got %h want %h", k, pc_f, 32'(4*k+4)); end
      end
   endtask

   task automatic test_stall_flush();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++; if (pc_f !== 32'h0C) begin miscompares++; $display("[TB] FAIL stall_pc_f got %h want 0c", pc_f); end
         vectors++; if (pc_d !== 32'h08) begin miscompares++; $display("[TB] FAIL stall_pc_d got %h want 08", pc_d); end
         vectors++; if (instr_d !== exp_mem[2]) begin miscompares++; $display("[TB] FAIL stall_instr got %h want %h", instr_d, exp_mem[2]); end
      end
      flush = 1'b1;
      step();
      vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid got %b want 0", valid_d); end
      vectors++; if (instr_d !== 32'h0) begin miscompares++; $display("[TB] FAIL flush_instr got %h want 0", instr_d); end
      vectors++; if (pc_f !== 32'h0C) begin miscompares++; $display("[TB] FAIL flush_pc_f got %h want 0c", pc_f); end
      stall = 1'b0; flush = 1'b0;
      step();
      vectors++; if (instr_d !== exp_mem[3]) begin miscompares++; $display("[TB] FAIL resume_instr got %h want %h", instr_d, exp_mem[3]); end
      vectors++; if (pc_d !== 32'h0C) begin miscompares++; $display("[TB] FAIL resume_pc_d got %h want 0c", pc_d); end
   endtask

   task automatic test_branch();
      pc_src = 1'b1; result = 32'h20;
      step();
      pc_src = 1'b0;
      vectors++; if (pc_f !== 32'h20) begin miscompares++; $display("[TB] FAIL br_pc_f got %h want 20", pc_f); end
      vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("[TB] FAIL br_valid got %b want 0", valid_d); end
      step();
      vectors++; if (instr_d !== exp_mem[8]) begin miscompares++; $display("[TB] FAIL br_instr got %h want %h", instr_d, exp_mem[8]); end
      vectors++; if (pc_d !== 32'h20) begin miscompares++; $display("[TB] FAIL br_pc_d got %h want 20", pc_d); end
      vectors++; if (pc_f !== 32'h24) begin miscompares++; $display("[TB] FAIL br_pc_f_next got %h want 24", pc_f); end
      stall = 1'b1; pc_src = 1'b1; result = 32'h10;
      step();
      stall = 1'b0; pc_src = 1'b0;
      vectors++; if (pc_f !== 32'h10) begin miscompares++; $display("[TB] FAIL br_over_stall_pc_f got %h want 10", pc_f); end
      vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("[TB] FAIL br_over_stall_valid got %b want 0", valid_d); end
      step();
      vectors++; if (instr_d !== exp_mem[4]) begin miscompares++; $display("[TB] FAIL br_over_stall_instr got %h want %h", instr_d, exp_mem[4]); end
   endtask

   task automatic test_regfile();
      pc_src = 1'b1; result = 32'h50;
      step();
      pc_src = 1'b0;
      step();
      stall = 1'b1; reg_src = 2'b00;
      reg_write = 1'b1; wb_addr = 4'd3; result = 32'd6;
      #1;
      vectors++; if (src_a !== 32'd6) begin miscompares++; $display("[TB] FAIL rf_bypass got %h want 6", src_a); end
      step();
      reg_write = 1'b0; result = 32'h0;
      #1;
      vectors++; if (src_a !== 32'd6) begin miscompares++; $display("[TB] FAIL rf_stored got %h want 6", src_a); end
      reg_write = 1'b1; wb_addr = 4'd2; result = 32'h22;
      step();
      reg_write = 1'b0;
      #1;
      vectors++; if (write_data !== 32'h22) begin miscompares++; $display("[TB] FAIL rf_wdata got %h want 22", write_data); end
      vectors++; if (src_b !== 32'h22) begin miscompares++; $display("[TB] FAIL rf_src_b_reg got %h want 22", src_b); end
      reg_src = 2'b10;
      #1;
      vectors++; if (write_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rf_rd_field got %h want 0", write_data); end
      reg_src = 2'b00;
      reg_write = 1'b1; wb_addr = 4'd6; result = 32'h66;
      step();
      reg_write = 1'b1; wb_addr = 4'd15; result = 32'hDEAD; reg_src = 2'b01;
      #1;
      vectors++; if (src_a !== 32'h58) begin miscompares++; $display("[TB] FAIL rf_pc_alias got %h want 58", src_a); end
      step();
      reg_write = 1'b0;
      #1;
      vectors++; if (src_a !== 32'h58) begin miscompares++; $display("[TB] FAIL rf_pc_alias_after got %h want 58", src_a); end
      reg_src = 2'b00; stall = 1'b0;
   endtask

   task automatic test_imm();
      step();
      stall = 1'b1; alu_src = 1'b1; imm_src = 2'b10;
      #1;
      vectors++; if (src_b !== 32'hFFFF_FFF8) begin miscompares++; $display("[TB] FAIL imm_branch got %h want fffffff8", src_b); end
      imm_src = 2'b00;
      #1;
      vectors++; if (src_b !== 32'h0000_00FE) begin miscompares++; $display("[TB] FAIL imm_zext8 got %h want fe", src_b); end
      imm_src = 2'b01;
      #1;
      vectors++; if (src_b !== 32'h0000_0FFE) begin miscompares++; $display("[TB] FAIL imm_zext12 got %h want ffe", src_b); end
      stall = 1'b0;
      step();
      stall = 1'b1; imm_src = 2'b11;
      #1;
      vectors++; if (src_b !== 32'hFF00_0000) begin miscompares++; $display("[TB] FAIL imm_rot got %h want ff000000", src_b); end
      alu_src = 1'b0;
      #1;
      vectors++; if (src_b !== 32'h60) begin miscompares++; $display("[TB] FAIL imm_off_alias got %h want 60", src_b); end
      stall = 1'b0; imm_src = 2'b00;
   endtask

   task automatic test_imem_write();
      pc_src = 1'b1; result = 32'h60;
      step();
      pc_src = 1'b0;
      imem_we = 1'b1; imem_waddr = 6'd24; imem_wdata = 32'h1234_5678;
      step();
      imem_we = 1'b0;
      vectors++; if (instr_d !== exp_mem[24]) begin miscompares++; $display("[TB] FAIL imem_same_cycle got %h want %h", instr_d, exp_mem[24]); end
      exp_mem[24] = 32'h1234_5678;
      pc_src = 1'b1; result = 32'h60;
      step();
      pc_src = 1'b0;
      step();
      vectors++; if (instr_d !== exp_mem[24]) begin miscompares++; $display("[TB] FAIL imem_new_word got %h want %h", instr_d, exp_mem[24]); end
   endtask

   task automatic test_wrap();
      pc_src = 1'b1; result = 32'hFFFF_FFFC;
      step();
      pc_src = 1'b0;
      step();
      vectors++; if (instr_d !== exp_mem[63]) begin miscompares++; $display("[TB] FAIL wrap_instr got %h want %h", instr_d, exp_mem[63]); end
      vectors++; if (pc_f !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_pc_f got %h want 0", pc_f); end
      pc_src = 1'b1; result = 32'h104;
      step();
      pc_src = 1'b0;
      step();
      vectors++; if (instr_d !== exp_mem[1]) begin miscompares++; $display("[TB] FAIL alias_instr got %h want %h", instr_d, exp_mem[1]); end
   endtask

   task automatic test_reset_priority();
      stall = 1'b1; pc_src = 1'b1; flush = 1'b1; result = 32'h40;
      reg_write = 1'b1; wb_addr = 4'd6; reset = 1'b0;
      step();
      vectors++; if (pc_f !== 32'h0) begin miscompares++; $display("[TB] FAIL rstpri_pc_f got %h want 0", pc_f); end
      vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("[TB] FAIL rstpri_valid got %b want 0", valid_d); end
      stall = 1'b0; pc_src = 1'b0; flush = 1'b0; reg_write = 1'b0; reset = 1'b1;
      step();
      vectors++; if (instr_d !== exp_mem[0]) begin miscompares++; $display("[TB] FAIL rstpri_instr got %h want %h", instr_d, exp_mem[0]); end
      vectors++; if (pc_d !== 32'h0) begin miscompares++; $display("[TB] FAIL rstpri_pc_d got %h want 0", pc_d); end
      vectors++; if (valid_d !== 1'b1) begin miscompares++; $display("[TB] FAIL rstpri_valid_after got %b want 1", valid_d); end
      vectors++; if (pc_f !== 32'h4) begin miscompares++; $display("[TB] FAIL rstpri_pc_f_after got %h want 4", pc_f); end
      vectors++; if (write_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rstpri_reg_cleared got %h want 0", write_data); end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      vectors = 0;
      miscompares = 0;
      build_image();
      load_program();
      test_reset();
      test_seq_fetch();
      test_stall_flush();
      test_branch();
      test_regfile();
      test_imm();
      test_imem_write();
      test_wrap();
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
